// File: rtl/vend_controller.sv
// Snack vending front-end sequencer: keypad capture, price check, credit, vend, change.
// Optional inactivity timeout is enabled by defining VEND_TIMEOUT_EN.
module vend_controller #(
  parameter int MAX_CREDIT     = 1000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        coin_valid,
  input  logic [9:0]  coin_value,
  input  logic        cancel,
  input  logic        inv_load,
  input  logic [39:0] inv_in,
  input  logic [10:0] snack_price,
  output logic [3:0]  sel_d1,
  output logic [3:0]  sel_d2,
  output logic [3:0]  sel_d3,
  output logic [39:0] inventory,
  output logic [10:0] credit,
  output logic        vend,
  output logic [5:0]  vend_index,
  output logic        change_valid,
  output logic [10:0] change_amount,
  output logic        sold_out,
  output logic        bad_code,
  output logic        coin_reject
);

  typedef enum logic [2:0] {
    S_IDLE, S_DIG2, S_DIG3, S_LOOKUP,
    S_PAY, S_VEND, S_CHANGE
  } state_t;

  state_t      r_state, w_state;
  logic [3:0]  r_d1, r_d2, r_d3;
  logic [3:0]  w_d1, w_d2, w_d3;
  logic [39:0] r_inv, w_inv;
  logic [10:0] r_credit, w_credit;
  logic [9:0]  r_price, w_price;
  logic        r_vend, w_vend;
  logic [5:0]  r_vidx, w_vidx;
  logic        r_chg_v, w_chg_v;
  logic [10:0] r_chg_amt, w_chg_amt;
  logic        r_sold, w_sold;
  logic        r_bad, w_bad;
  logic        r_crej, w_crej;

  logic [3:0]  w_digit;
  logic [5:0]  w_idx;
  logic [11:0] w_sum;
  logic        w_active;
  logic        w_abort;
  logic        w_tmo;

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
    end else if (key_valid || coin_valid || (w_state != r_state)) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo = (r_tmo_cnt == TW'(TIMEOUT_CYCLES)) &&
                 ((r_state == S_DIG2) || (r_state == S_DIG3) ||
                  (r_state == S_PAY));
`else
  // no timer in this build; a non-negative limit never fires
  assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

  assign w_digit  = (key_digit > 4'd9) ? 4'd0 : key_digit;
  assign w_sum    = {1'b0, r_credit} + {2'b00, coin_value};
  assign w_active = (r_state != S_VEND) && (r_state != S_CHANGE);
  assign w_abort  = w_active && (cancel || w_tmo);

  always_comb begin
    w_idx = '0;
    unique case (r_d2)
      4'd0, 4'd1, 4'd2, 4'd3:
        w_idx = 6'({2'b00, r_d2} * 6'd5) + {3'b000, r_d3[3:1]};
      4'd4: w_idx = 6'd20 + {2'b00, r_d3};
      4'd5: w_idx = 6'd30 + {3'b000, r_d3[3:1]};
      4'd6: w_idx = 6'd35 + {2'b00, r_d3};
      default: w_idx = '0;
    endcase
  end

  always_comb begin
    w_state   = r_state;
    w_d1      = r_d1;
    w_d2      = r_d2;
    w_d3      = r_d3;
    w_inv     = r_inv;
    w_credit  = r_credit;
    w_price   = r_price;
    w_vend    = 1'b0;
    w_vidx    = r_vidx;
    w_chg_v   = 1'b0;
    w_chg_amt = r_chg_amt;
    w_sold    = 1'b0;
    w_bad     = 1'b0;
    w_crej    = 1'b0;

    if (coin_valid) begin
      if (!w_active || w_abort || (coin_value == '0) ||
          (w_sum > 12'(MAX_CREDIT))) begin
        w_crej = 1'b1;
      end else begin
        w_credit = w_sum[10:0];
      end
    end

    if (w_abort) begin
      w_d1     = '0;
      w_d2     = '0;
      w_d3     = '0;
      w_credit = '0;
      w_state  = S_IDLE;
      if (r_credit != '0) begin
        w_chg_v   = 1'b1;
        w_chg_amt = r_credit;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (key_valid) begin
            w_d1    = w_digit;
            w_d2    = '0;
            w_d3    = '0;
            w_state = S_DIG2;
          end else if (inv_load) begin
            w_inv = inv_in;
          end
        end
        S_DIG2: begin
          if (key_valid) begin
            w_d2    = w_digit;
            w_state = S_DIG3;
          end
        end
        S_DIG3: begin
          if (key_valid) begin
            w_d3    = w_digit;
            w_state = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (snack_price[9:0] == '0) begin
            w_bad   = 1'b1;
            w_state = S_IDLE;
          end else if (!snack_price[10]) begin
            w_sold  = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_price = snack_price[9:0];
            w_state = S_PAY;
          end
        end
        S_PAY: begin
          if (r_credit >= {1'b0, r_price}) w_state = S_VEND;
        end
        S_VEND: begin
          w_vend   = 1'b1;
          w_vidx   = w_idx;
          // indices past the last slot shift out and leave inventory intact
          w_inv    = r_inv & ~(40'd1 << w_idx);
          w_credit = r_credit - {1'b0, r_price};
          w_state  = S_CHANGE;
        end
        S_CHANGE: begin
          if (r_credit != '0) begin
            w_chg_v   = 1'b1;
            w_chg_amt = r_credit;
          end
          w_credit = '0;
          w_state  = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_d1      <= '0;
      r_d2      <= '0;
      r_d3      <= '0;
      r_inv     <= '0;
      r_credit  <= '0;
      r_price   <= '0;
      r_vend    <= 1'b0;
      r_vidx    <= '0;
      r_chg_v   <= 1'b0;
      r_chg_amt <= '0;
      r_sold    <= 1'b0;
      r_bad     <= 1'b0;
      r_crej    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_d1      <= w_d1;
      r_d2      <= w_d2;
      r_d3      <= w_d3;
      r_inv     <= w_inv;
      r_credit  <= w_credit;
      r_price   <= w_price;
      r_vend    <= w_vend;
      r_vidx    <= w_vidx;
      r_chg_v   <= w_chg_v;
      r_chg_amt <= w_chg_amt;
      r_sold    <= w_sold;
      r_bad     <= w_bad;
      r_crej    <= w_crej;
    end
  end

  assign sel_d1        = r_d1;
  assign sel_d2        = r_d2;
  assign sel_d3        = r_d3;
  assign inventory     = r_inv;
  assign credit        = r_credit;
  assign vend          = r_vend;
  assign vend_index    = r_vidx;
  assign change_valid  = r_chg_v;
  assign change_amount = r_chg_amt;
  assign sold_out      = r_sold;
  assign bad_code      = r_bad;
  assign coin_reject   = r_crej;

endmodule
